// File: rtl/twos_to_signmag_seq_if.sv
// Handshake bundle for the two's-complement to sign-magnitude converter.
// The slave modport is the converter's view; master is the producer/consumer side.
interface twos_to_signmag_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_flag;
    logic [WIDTH-1:0] out_mag;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_flag, out_mag, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_flag, out_mag, busy
    );
endinterface

// File: rtl/twos_to_signmag_seq.sv
// Two's complement to sign-magnitude converter; negatives are negated bit-serially,
// LSB first ("copy through the first 1, invert the rest"), one operand in flight.
module twos_to_signmag_seq #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    twos_to_signmag_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             seen_one;
    logic             flag;
    logic [WIDTH-1:0] mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            flag     <= 1'b0;
            mag      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!bus.in_data[WIDTH-1]) begin
                            mag   <= bus.in_data;
                            flag  <= 1'b0;
                            state <= DONE;
                        end else begin
                            sreg     <= bus.in_data;
                            flag     <= 1'b1;
                            cnt      <= '0;
                            seen_one <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Result enters at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
                    mag      <= {(seen_one ? ~sreg[0] : sreg[0]), mag[WIDTH-1:1]};
                    seen_one <= seen_one | sreg[0];
                    sreg     <= sreg >> 1;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_flag  = flag;
    assign bus.out_mag   = mag;
endmodule

// File: tb/tb_twos_to_signmag_seq.sv
// Self-checking bench for twos_to_signmag_seq: scoreboard of expected (flag, mag)
// pushed at each accept and compared when the result is handed over.
module tb_twos_to_signmag_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic       flag;
        logic [7:0] mag;
    } res_t;

    res_t sb[$];

    twos_to_signmag_seq_if #(.WIDTH(8)) ifc ();

    twos_to_signmag_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] d);
        res_t r;
        r.flag = d[7];
        r.mag  = d[7] ? 8'(0 - int'(d)) : d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present d for one edge, push its expected result.
    task automatic accept(input logic [7:0] d);
        int n = 0;
        while (!ifc.in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!ifc.in_ready) begin
            errors++;
            $display("FAIL accept_timeout data=%h in_ready=%b required 1", d, ifc.in_ready);
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        tick();
        ifc.in_valid = 1'b0;
        sb.push_back(model(d));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ifc.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    // Compare current output with scoreboard head, then complete the handshake.
    task automatic take_result(input string name);
        res_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty flag=%b mag=%h", name, ifc.out_flag, ifc.out_mag);
        end else begin
            e = sb.pop_front();
            if (ifc.out_valid !== 1'b1 || ifc.out_flag !== e.flag || ifc.out_mag !== e.mag) begin
                errors++;
                $display("FAIL %s_result valid=%b flag=%b mag=%h required valid=1 flag=%b mag=%h",
                         name, ifc.out_valid, ifc.out_flag, ifc.out_mag, e.flag, e.mag);
            end
        end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_return_idle in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     name, ifc.in_ready, ifc.out_valid, ifc.busy);
        end
    endtask

    task automatic check_lat(input string name, input int lat, input int req);
        checks++;
        if (lat !== req) begin
            errors++;
            $display("FAIL %s_latency got=%0d required=%0d", name, lat, req);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.out_flag !== 1'b0 ||
            ifc.out_mag !== 8'h00 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready=%b out_valid=%b flag=%b mag=%h busy=%b required 1 0 0 00 0",
                     name, ifc.in_ready, ifc.out_valid, ifc.out_flag, ifc.out_mag, ifc.busy);
        end
    endtask

    task automatic test_reset();
        int lat;
        #1;
        check_reset_vals("reset_initial");
        tick();
        #2 rst = 1'b0;
        tick();
        accept(8'hF3);
        repeat (3) tick();
        checks++;
        if (ifc.busy !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_shift busy=%b out_valid=%b required 1 0", ifc.busy, ifc.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        check_reset_vals("reset_mid_shift");
        sb.delete();
        #1 rst = 1'b0;
        tick();
        accept(8'h05);
        wait_valid(lat);
        check_lat("reset_recover", lat, 0);
        take_result("reset_recover");
    endtask

    task automatic test_positive();
        int lat;
        accept(8'h2A);
        wait_valid(lat);
        check_lat("positive", lat, 0);
        repeat (3) begin
            tick();
            checks++;
            if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL positive_hold in_ready=%b out_valid=%b required 0 1", ifc.in_ready, ifc.out_valid);
            end
        end
        take_result("positive");
    endtask

    task automatic test_negative();
        int lat;
        accept(8'hD6);
        wait_valid(lat);
        check_lat("negative_d6", lat, 8);
        take_result("negative_d6");
        accept(8'hFF);
        wait_valid(lat);
        check_lat("negative_ff", lat, 8);
        take_result("negative_ff");
    endtask

    task automatic test_boundaries();
        int lat;
        logic [7:0] vals [3];
        vals = '{8'h80, 8'h00, 8'h7F};
        foreach (vals[i]) begin
            accept(vals[i]);
            wait_valid(lat);
            check_lat($sformatf("boundary_%h", vals[i]), lat, vals[i][7] ? 8 : 0);
            take_result($sformatf("boundary_%h", vals[i]));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        accept(8'h9C);
        wait_valid(lat);
        check_lat("backpressure", lat, 8);
        for (int i = 0; i < 10; i++) begin
            ifc.in_valid = i[0];
            ifc.in_data  = 8'h11;
            tick();
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_flag !== 1'b1 || ifc.out_mag !== 8'h64 ||
                ifc.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b flag=%b mag=%h in_ready=%b required 1 1 64 0",
                         i, ifc.out_valid, ifc.out_flag, ifc.out_mag, ifc.in_ready);
            end
        end
        ifc.in_valid = 1'b0;
        take_result("backpressure");
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        int idx = 0, done = 0, cyc = 0, done_cyc = -10;
        res_t e;
        seq = '{8'h01, 8'hFE, 8'h80, 8'h7F};
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = seq[0];
        while (done < 4 && cyc < 200) begin
            if (ifc.in_valid && ifc.in_ready) begin
                sb.push_back(model(ifc.in_data));
                if (idx > 0) begin
                    checks++;
                    if (cyc != done_cyc + 1) begin
                        errors++;
                        $display("FAIL b2b_gap accept_cyc=%0d required=%0d", cyc, done_cyc + 1);
                    end
                end
                idx++;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_scoreboard_empty flag=%b mag=%h", ifc.out_flag, ifc.out_mag);
                end else begin
                    e = sb.pop_front();
                    if (ifc.out_flag !== e.flag || ifc.out_mag !== e.mag) begin
                        errors++;
                        $display("FAIL b2b_result_%0d flag=%b mag=%h required flag=%b mag=%h",
                                 done, ifc.out_flag, ifc.out_mag, e.flag, e.mag);
                    end
                end
                done++;
                done_cyc = cyc;
            end
            tick();
            cyc++;
            if (idx < 4) ifc.in_data = seq[idx];
            else ifc.in_valid = 1'b0;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        checks++;
        if (done != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count results=%0d required=4 leftover=%0d", done, sb.size());
        end
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_positive();
        test_negative();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
